serial_byte_rx: RTL and testbench
=================================

Name: serial_byte_rx

Overview:
- Upstream feeder for the ones-count/parity counter stage.
- Receives 8N1 asynchronous serial frames (LSB first) and presents each assembled byte on a parallel bus.
- Pulses `init` for one cycle to start the counter, then holds the byte until the counter reports `done`.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be an even value >= 4.
- DATA_W, 8, data bits per frame; must match the counter's data_in width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial line; idle high.
- done_in  in  1  level from the downstream counter's done output.
- data_out  out  DATA_W  assembled byte; drives the counter's data_in.
- init  out  1  one-cycle start pulse; drives the counter's init.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky; a start edge arrived while waiting for done_in.
- frame_err  out  1  stop-bit error pulse (see Optional Feature).

Behaviour:
- Reset values, on a posedge clk with rst=0:
  - state=IDLE; data_out=0; init=0; busy=0; overrun=0; frame_err=0.
  - Shift register=0; bit index=0; baud counter=0; both rx sync flops=1.
- Reset mid-frame or mid-wait aborts immediately to IDLE. No init is issued.
- Synchronisation: rx passes through 2 flops to give rx_s. All decisions use rx_s.
- Baud counter: down-counter. A sample point is the cycle it reads 0.
- FSM states: IDLE, START, DATA, STOP, ISSUE, WAIT_DONE.
- IDLE: rx_s=0 -> go to START; load baud counter with CLKS_PER_BIT/2-1.
- START: at the sample point:
  - rx_s=0 -> go to DATA; load CLKS_PER_BIT-1; bit index=0.
  - rx_s=1 (glitch) -> return to IDLE; no output change.
- DATA: at each sample point:
  - Shift right; rx_s enters the MSB.
  - Bit index +1; reload CLKS_PER_BIT-1.
  - After the DATA_W-th sample -> go to STOP.
- STOP: at the sample point -> go to ISSUE (frame-error handling per Optional Feature).
- ISSUE (1 cycle):
  - data_out <= shift register; init=1.
  - Next state WAIT_DONE.
  - init is 0 in every other state.
- WAIT_DONE:
  - data_out is held constant.
  - done_in=1 -> go to IDLE on the next edge.
  - done_in is ignored in all other states, including the ISSUE cycle.
- Overrun: in WAIT_DONE, a 1->0 transition on rx_s sets overrun=1.
  - That frame is dropped.
  - overrun clears only on reset.
- Latency: init is high exactly one cycle after the stop-bit sample point.
  - Nominal: 3 + CLKS_PER_BIT/2 + (DATA_W+1)*CLKS_PER_BIT cycles after rx falls.
- Back-to-back frames: receive the next start bit only after returning to IDLE.
  - A stop bit of at least 1 bit time plus the downstream done time is required.
- busy is combinational: busy = (state != IDLE).

Optional Feature:
- Macro: SERIAL_BYTE_RX_FRAME_ERR_EN.
- Defined:
  - At the STOP sample, rx_s=0 -> frame_err=1 for one cycle; return to IDLE.
  - No init is issued; data_out keeps its previous value.
  - rx_s=1 -> go to ISSUE as normal.
- Undefined:
  - The stop-bit value is ignored; always go to ISSUE.
  - frame_err is tied to 0.

Test Plan:
- Single frame, CLKS_PER_BIT=4, byte 8'h4F (rx: 0, 1,1,1,1,0,0,1,0, 1):
  - data_out=8'h4F; init high for exactly 1 cycle at the nominal latency (41 cycles).
  - busy stays high until done_in.
- Hold until done_in: done_in is held 0 for 20 cycles, then pulsed 1 for 1 cycle.
  - data_out is stable at 8'h4F throughout.
  - IDLE is entered (busy=0) on the cycle after done_in.
- Glitch rejection: rx low for 1 cycle, then high.
  - FSM returns to IDLE at the START sample; init never asserts; data_out is unchanged.
- Overrun: a second frame (8'hA5) starts while in WAIT_DONE.
  - overrun=1 and stays 1; data_out remains 8'h4F.
  - No second init until a fresh frame after done_in.
- Reset mid-frame: rst=0 for 2 cycles during the 4th data bit.
  - All outputs are 0 and state is IDLE.
  - The next full frame 8'h3C is received correctly.
- With SERIAL_BYTE_RX_FRAME_ERR_EN, stop bit driven 0 on byte 8'h81:
  - frame_err pulses 1 cycle; no init; data_out keeps its old value.
  - Without the macro, the same stimulus yields init and data_out=8'h81.

Source files
------------

// File: rtl/serial_byte_rx.sv
// serial_byte_rx
// Receives 8N1 asynchronous serial frames, LSB first. Each assembled byte is
// sent to the ones-count/parity counter stage. The block pulses init for one
// cycle, then holds the byte until the counter reports done.
//
// Optional feature macro: SERIAL_BYTE_RX_FRAME_ERR_EN
//   defined   - a low stop bit raises frame_err for one cycle and drops the frame
//   undefined - the stop-bit value is ignored and frame_err is tied low
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous reset, active low
//   rx         asynchronous serial line, idle high
//   done_in    level from the downstream counter's done output
//   data_out   assembled byte, drives the counter's data_in
//   init       one-cycle start pulse for the counter
//   busy       high whenever the receiver is not idle (combinational)
//   overrun    sticky, a start edge arrived while waiting for done_in
//   frame_err  stop-bit error pulse
module serial_byte_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              done_in,
    output logic [DATA_W-1:0] data_out,
    output logic              init,
    output logic              busy,
    output logic              overrun,
    output logic              frame_err
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_rx_s;
    logic              r_rx_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic              r_init;
    logic              w_init_nxt;
    logic              r_overrun;
    logic              w_overrun_nxt;
    logic              w_sample;
    logic              w_rx_fall;
`ifdef SERIAL_BYTE_RX_FRAME_ERR_EN
    logic              r_frame_err;
    logic              w_frame_err_nxt;
`endif

    // The sample point is the cycle in which the baud down-counter reads zero.
    assign w_sample  = (r_cnt == '0);
    // r_rx_d delays rx_s by one cycle, so a 1->0 step marks a new start edge.
    assign w_rx_fall = r_rx_d & ~r_rx_s;

    // State, datapath and output registers; the 2-flop synchroniser resets to idle-high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_init    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sync1   <= rx;
            r_rx_s    <= r_sync1;
            r_rx_d    <= r_rx_s;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_init    <= w_init_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

`ifdef SERIAL_BYTE_RX_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err_nxt;
        end
    end
`endif

    // Next-state and next-output logic.
    // init and data_out are loaded on the stop-sample edge, so both are valid
    // during the single ISSUE cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_sample ? r_cnt : r_cnt - CNT_W'(1);
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_init_nxt    = 1'b0;
        w_overrun_nxt = r_overrun;
`ifdef SERIAL_BYTE_RX_FRAME_ERR_EN
        w_frame_err_nxt = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = HALF_LOAD;
                end
            end

            S_START: begin
                if (w_sample) begin
                    if (!r_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = FULL_LOAD;
                        w_idx_nxt   = '0;
                    end else begin
                        // Start bit was a glitch: drop it silently.
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (w_sample) begin
                    w_shift_nxt = {r_rx_s, r_shift[DATA_W-1:1]};
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_cnt_nxt   = FULL_LOAD;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (w_sample) begin
`ifdef SERIAL_BYTE_RX_FRAME_ERR_EN
                    if (!r_rx_s) begin
                        w_state_nxt     = S_IDLE;
                        w_frame_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_data_nxt  = r_shift;
                        w_init_nxt  = 1'b1;
                    end
`else
                    w_state_nxt = S_ISSUE;
                    w_data_nxt  = r_shift;
                    w_init_nxt  = 1'b1;
`endif
                end
            end

            S_ISSUE: begin
                w_state_nxt = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                // A frame that starts here is dropped and only flagged.
                if (w_rx_fall) begin
                    w_overrun_nxt = 1'b1;
                end
                if (done_in) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign data_out = r_data;
    assign init     = r_init;
    assign busy     = (r_state != S_IDLE);
    assign overrun  = r_overrun;
`ifdef SERIAL_BYTE_RX_FRAME_ERR_EN
    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx
// Self-checking bench for serial_byte_rx with CLKS_PER_BIT=4 and DATA_W=8.
// Frames are driven at ideal bit timing. The reference model predicts each
// frame's outcome from the frame contents:
//   - the init cycle is the start-fall cycle plus the nominal latency
//   - the issued byte is the byte that was sent
//   - frame_err or overrun is predicted from the same frame.
`timescale 1ns/1ps
module tb_serial_byte_rx;

    localparam int unsigned CPB     = 4;
    localparam int unsigned DW      = 8;
    localparam int          LATENCY = 3 + CPB / 2 + (DW + 1) * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          done_in;
    logic [DW-1:0] data_out;
    logic          init;
    logic          busy;
    logic          overrun;
    logic          frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Records of every cycle in which init or frame_err was high.
    int          init_cyc_q[$];
    logic [DW-1:0] init_dat_q[$];
    int          fe_cyc_q[$];

    logic [DW-1:0] exp_data;

    serial_byte_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .done_in   (done_in),
        .data_out  (data_out),
        .init      (init),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (init === 1'b1) begin
            init_cyc_q.push_back(cyc);
            init_dat_q.push_back(data_out);
        end
        if (frame_err === 1'b1) begin
            fe_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    // Drive one full frame; fall is the cycle count at which rx went low.
    task automatic send_frame(input logic [DW-1:0] b, input logic stop_v, output int fall);
        fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < int'(DW); i++) drive_bit(b[i]);
        drive_bit(stop_v);
        rx = 1'b1;
    endtask

    task automatic clear_q();
        init_cyc_q.delete();
        init_dat_q.delete();
        fe_cyc_q.delete();
    endtask

    task automatic expect_frame(input string tag, input int fall, input logic [DW-1:0] b);
        tick(3);
        chk({tag, "_init_cnt"}, 32'(init_cyc_q.size()), 32'd1);
        if (init_cyc_q.size() > 0) begin
            chk({tag, "_init_cyc"}, 32'(init_cyc_q[0]), 32'(fall + LATENCY));
            chk({tag, "_init_data"}, 32'(init_dat_q[0]), 32'(b));
        end
        chk({tag, "_fe_cnt"}, 32'(fe_cyc_q.size()), 32'd0);
        chk({tag, "_data_out"}, 32'(data_out), 32'(b));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        exp_data = b;
        clear_q();
    endtask

    task automatic pulse_done(input string tag);
        chk({tag, "_busy_pre"}, 32'(busy), 32'd1);
        done_in = 1'b1;
        tick(1);
        done_in = 1'b0;
        chk({tag, "_busy_post"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int          fall;
        logic [DW-1:0] b;
        logic        stop_v;
        int          wait_n;

        rst      = 1'b0;
        rx       = 1'b1;
        done_in  = 1'b0;
        exp_data = '0;
        tick(3);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_init", 32'(init), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        tick(4);
        clear_q();

        // Single frame 0x4F, then hold for 20 cycles before done.
        send_frame(8'h4F, 1'b1, fall);
        expect_frame("f4f", fall, 8'h4F);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("hold_data", 32'(data_out), 32'h4F);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        chk("hold_no_init", 32'(init_cyc_q.size()), 32'd0);
        pulse_done("f4f_done");
        tick(2 * CPB);

        // One-cycle glitch on rx: START is entered, then abandoned.
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(2);
        chk("glitch_busy_start", 32'(busy), 32'd1);
        tick(7);
        chk("glitch_busy_idle", 32'(busy), 32'd0);
        chk("glitch_no_init", 32'(init_cyc_q.size()), 32'd0);
        chk("glitch_no_fe", 32'(fe_cyc_q.size()), 32'd0);
        chk("glitch_data", 32'(data_out), 32'(exp_data));
        clear_q();

        // Overrun: a frame sent while waiting for done_in is dropped.
        send_frame(8'h4F, 1'b1, fall);
        expect_frame("ovr_first", fall, 8'h4F);
        send_frame(8'hA5, 1'b1, fall);
        tick(3);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_data_held", 32'(data_out), 32'h4F);
        chk("ovr_no_init", 32'(init_cyc_q.size()), 32'd0);
        pulse_done("ovr_done");
        chk("ovr_sticky", 32'(overrun), 32'd1);
        tick(2 * CPB);
        b = 8'($urandom);
        send_frame(b, 1'b1, fall);
        expect_frame("ovr_fresh", fall, b);
        pulse_done("ovr_fresh_done");
        chk("ovr_sticky2", 32'(overrun), 32'd1);
        tick(2 * CPB);

        // Reset during the 4th data bit; the line returns to idle while reset is low.
        b = 8'h4F;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rx = b[3];
        tick(1);
        rst = 1'b0;
        rx  = 1'b1;
        tick(2);
        rst = 1'b1;
        chk("mid_rst_data_out", 32'(data_out), 32'd0);
        chk("mid_rst_init", 32'(init), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
        exp_data = '0;
        tick(4 * CPB);
        chk("mid_rst_no_init", 32'(init_cyc_q.size()), 32'd0);
        clear_q();
        send_frame(8'h3C, 1'b1, fall);
        expect_frame("f3c", fall, 8'h3C);
        pulse_done("f3c_done");
        tick(2 * CPB);

        // Stop bit driven low on 0x81.
        send_frame(8'h81, 1'b0, fall);
`ifdef SERIAL_BYTE_RX_FRAME_ERR_EN
        tick(3);
        chk("fe_cnt", 32'(fe_cyc_q.size()), 32'd1);
        if (fe_cyc_q.size() > 0) chk("fe_cyc", 32'(fe_cyc_q[0]), 32'(fall + LATENCY));
        chk("fe_no_init", 32'(init_cyc_q.size()), 32'd0);
        chk("fe_data_held", 32'(data_out), 32'(exp_data));
        tick(2 * CPB);
        chk("fe_busy_idle", 32'(busy), 32'd0);
        clear_q();
`else
        expect_frame("f81_badstop", fall, 8'h81);
        chk("f81_frame_err", 32'(frame_err), 32'd0);
        pulse_done("f81_done");
`endif
        tick(2 * CPB);

        // Random frames: random byte, stop value, idle gap and done delay.
        for (int n = 0; n < 12; n++) begin
            b      = 8'($urandom);
            stop_v = ($urandom_range(0, 3) != 0);
            wait_n = int'($urandom_range(0, 10));
            tick(int'($urandom_range(CPB, 3 * CPB)));
            send_frame(b, stop_v, fall);
`ifdef SERIAL_BYTE_RX_FRAME_ERR_EN
            if (!stop_v) begin
                tick(3);
                chk("rnd_fe_cnt", 32'(fe_cyc_q.size()), 32'd1);
                if (fe_cyc_q.size() > 0) chk("rnd_fe_cyc", 32'(fe_cyc_q[0]), 32'(fall + LATENCY));
                chk("rnd_fe_no_init", 32'(init_cyc_q.size()), 32'd0);
                chk("rnd_fe_data", 32'(data_out), 32'(exp_data));
                clear_q();
                tick(2 * CPB);
                continue;
            end
`endif
            expect_frame("rnd", fall, b);
            tick(wait_n);
            chk("rnd_hold_data", 32'(data_out), 32'(b));
            pulse_done("rnd_done");
        end

        tick(2 * CPB);
        chk("end_overrun", 32'(overrun), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_data", 32'(data_out), 32'(exp_data));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
